// File: rtl/ibex_mem_pkg.sv
// Shared types and defaults for the Ibex instruction/data memory arbiter.
package ibex_mem_pkg;

    // Which port, if any, receives a response in the cycle after a grant.
    // The ERR_* states mark an access that was refused without touching the RAM.
    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA,
        OWN_ERR_I,
        OWN_ERR_D
    } owner_e;

    // Default write-protected window [base, limit) in byte addresses.
    localparam logic [31:0] PROT_BASE_DEFAULT  = 32'h0000_2000;
    localparam logic [31:0] PROT_LIMIT_DEFAULT = 32'h0000_3000;

    // The violation counter saturates at this value.
    localparam logic [15:0] VIOL_CNT_MAX = 16'hFFFF;

    // True when base <= addr < limit.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/ibex_mem_arb_if.sv
// One core-side memory port: request/address/write data in, grant and response out.
interface ibex_mem_arb_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    // The core side issues requests and receives grants/responses.
    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    // The arbiter side sees requests and returns grants/responses.
    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/ibex_mem_prot_chk.sv
// Combinational address decode for one port: is the access inside the RAM and
// not a store into the write-protected window?
module ibex_mem_prot_chk
    import ibex_mem_pkg::*;
#(
    parameter int unsigned Depth     = 16384,
    parameter logic [31:0] ProtBase  = PROT_BASE_DEFAULT,
    parameter logic [31:0] ProtLimit = PROT_LIMIT_DEFAULT
) (
    ibex_mem_arb_if.slave bus,
    output logic          ok,
    output logic          viol
);

    // RAM size in bytes; one extra bit so Depth*4 never wraps.
    localparam logic [32:0] RamBytes = 33'(Depth) * 33'd4;

    logic in_ram;

    assign in_ram = ({1'b0, bus.addr} < RamBytes);

    // Loads and fetches may read the protected window; only stores are refused.
    assign viol = bus.we && addr_in_window(bus.addr, ProtBase, ProtLimit);

    assign ok = in_ram && !viol;

endmodule

// File: rtl/ibex_mem_arb.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-port
// RAM with a fixed one-cycle read latency. Grants are combinational, ties are
// round-robin, and illegal or write-protected accesses are answered with an
// error response without reaching the RAM.
module ibex_mem_arb
    import ibex_mem_pkg::*;
#(
    parameter int unsigned Depth     = 16384,
    parameter logic [31:0] ProtBase  = PROT_BASE_DEFAULT,
    parameter logic [31:0] ProtLimit = PROT_LIMIT_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     instr_req_i,
    input  logic [31:0]              instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [31:0]              instr_rdata_o,
    output logic                     instr_err_o,

    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    output logic [31:0]              data_rdata_o,
    output logic                     data_err_o,

    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic [$clog2(Depth)-1:0] mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,

    output logic [15:0]              viol_cnt_o
);

    localparam int unsigned Aw = $clog2(Depth);

    // ------------------------------------------------------------------
    // Port bundles. The fetch port is a read-only, full-word port.
    // ------------------------------------------------------------------
    ibex_mem_arb_if instr_bus ();
    ibex_mem_arb_if data_bus ();

    assign instr_bus.req   = instr_req_i;
    assign instr_bus.we    = 1'b0;
    assign instr_bus.be    = 4'hF;
    assign instr_bus.addr  = instr_addr_i;
    assign instr_bus.wdata = '0;

    assign data_bus.req    = data_req_i;
    assign data_bus.we     = data_we_i;
    assign data_bus.be     = data_be_i;
    assign data_bus.addr   = data_addr_i;
    assign data_bus.wdata  = data_wdata_i;

    // ------------------------------------------------------------------
    // Address legality per port.
    // ------------------------------------------------------------------
    logic instr_ok;
    logic unused_instr_viol;
    logic data_ok;
    logic data_viol;

    ibex_mem_prot_chk #(
        .Depth     (Depth),
        .ProtBase  (ProtBase),
        .ProtLimit (ProtLimit)
    ) u_instr_chk (
        .bus  (instr_bus),
        .ok   (instr_ok),
        .viol (unused_instr_viol)
    );

    ibex_mem_prot_chk #(
        .Depth     (Depth),
        .ProtBase  (ProtBase),
        .ProtLimit (ProtLimit)
    ) u_data_chk (
        .bus  (data_bus),
        .ok   (data_ok),
        .viol (data_viol)
    );

    // The RAM always answers exactly one cycle after a request, so the owner
    // register alone marks the response cycle; the RAM's own valid is redundant.
    logic unused_mem_rvalid;
    assign unused_mem_rvalid = mem_rvalid_i;

    // ------------------------------------------------------------------
    // Grant: one port per cycle, round-robin on a tie.
    // ------------------------------------------------------------------
    logic prio_instr;   // 1: the fetch port wins the next tie
    logic gnt_instr;
    logic gnt_data;

    // Pick at most one requester; nothing is granted while reset is held.
    // NOTE: every output gets a default before the branches so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (!rst_i) begin
            if (instr_req_i && data_req_i) begin
                gnt_instr = prio_instr;
                gnt_data  = !prio_instr;
            end else begin
                gnt_instr = instr_req_i;
                gnt_data  = data_req_i;
            end
        end
    end

    // The port granted most recently loses the next tie; data is favoured after reset.
    // NOTE: registers use non-blocking assignments so each one samples values from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_instr <= 1'b0;
        end else if (gnt_data) begin
            prio_instr <= 1'b1;
        end else if (gnt_instr) begin
            prio_instr <= 1'b0;
        end
    end

    assign instr_bus.gnt = gnt_instr;
    assign data_bus.gnt  = gnt_data;
    assign instr_gnt_o   = instr_bus.gnt;
    assign data_gnt_o    = data_bus.gnt;

    // ------------------------------------------------------------------
    // Owner FSM: remembers who gets the response in the next cycle.
    // ------------------------------------------------------------------
    owner_e owner_q;
    owner_e owner_d;

    // Owner state register; reset drops any access granted just before it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Load the owner from this cycle's grant, or NONE when nothing is granted.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt_instr) begin
            owner_d = instr_ok ? OWN_INSTR : OWN_ERR_I;
        end else if (gnt_data) begin
            owner_d = data_ok ? OWN_DATA : OWN_ERR_D;
        end
    end

    logic        instr_rvalid;
    logic        instr_err;
    logic [31:0] instr_rdata;
    logic        data_rvalid;
    logic        data_err;
    logic [31:0] data_rdata;

    // Steer the response to the owning port; idle ports see all zeros.
    always_comb begin
        instr_rvalid = 1'b0;
        instr_err    = 1'b0;
        instr_rdata  = '0;
        data_rvalid  = 1'b0;
        data_err     = 1'b0;
        data_rdata   = '0;
        if (!rst_i) begin
            case (owner_q)
                OWN_INSTR: begin
                    instr_rvalid = 1'b1;
                    instr_rdata  = mem_rdata_i;
                end
                OWN_ERR_I: begin
                    instr_rvalid = 1'b1;
                    instr_err    = 1'b1;
                end
                OWN_DATA: begin
                    data_rvalid = 1'b1;
                    data_rdata  = mem_rdata_i;
                end
                OWN_ERR_D: begin
                    data_rvalid = 1'b1;
                    data_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_bus.rvalid = instr_rvalid;
    assign instr_bus.err    = instr_err;
    assign instr_bus.rdata  = instr_rdata;
    assign data_bus.rvalid  = data_rvalid;
    assign data_bus.err     = data_err;
    assign data_bus.rdata   = data_rdata;

    assign instr_rvalid_o = instr_bus.rvalid;
    assign instr_err_o    = instr_bus.err;
    assign instr_rdata_o  = instr_bus.rdata;
    assign data_rvalid_o  = data_bus.rvalid;
    assign data_err_o     = data_bus.err;
    assign data_rdata_o   = data_bus.rdata;

    // ------------------------------------------------------------------
    // RAM request: only granted, legal accesses reach the RAM.
    // ------------------------------------------------------------------

    // Route the granted legal access to the RAM; all mem_* are zero when idle.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_instr && instr_ok) begin
            mem_req_o   = 1'b1;
            mem_we_o    = instr_bus.we;
            mem_be_o    = instr_bus.be;
            mem_addr_o  = instr_bus.addr[Aw+1:2];
            mem_wdata_o = instr_bus.wdata;
        end else if (gnt_data && data_ok) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_bus.we;
            mem_be_o    = data_bus.be;
            mem_addr_o  = data_bus.addr[Aw+1:2];
            mem_wdata_o = data_bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Protection-violation counter.
    // ------------------------------------------------------------------
    logic [15:0] viol_cnt_q;

    // Count granted stores into the protected window, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            viol_cnt_q <= '0;
        end else if (gnt_data && data_viol && (viol_cnt_q != VIOL_CNT_MAX)) begin
            viol_cnt_q <= viol_cnt_q + 16'd1;
        end
    end

    assign viol_cnt_o = viol_cnt_q;

endmodule

// File: tb/tb_ibex_mem_arb.sv
// Testbench for ibex_mem_arb: directed per-cycle stimulus with hand-computed
// expected responses queued per port, checked by an independent monitor.
module tb_ibex_mem_arb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ibex_mem_arb_if ibus ();
    ibex_mem_arb_if dbus ();

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] viol_cnt;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    resp_t iq[$];
    resp_t dq[$];
    resp_t ie;
    resp_t de;

    logic [31:0] ram [0:16383];

    ibex_mem_arb dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (ibus.req),
        .instr_addr_i   (ibus.addr),
        .instr_gnt_o    (ibus.gnt),
        .instr_rvalid_o (ibus.rvalid),
        .instr_rdata_o  (ibus.rdata),
        .instr_err_o    (ibus.err),
        .data_req_i     (dbus.req),
        .data_we_i      (dbus.we),
        .data_be_i      (dbus.be),
        .data_addr_i    (dbus.addr),
        .data_wdata_i   (dbus.wdata),
        .data_gnt_o     (dbus.gnt),
        .data_rvalid_o  (dbus.rvalid),
        .data_rdata_o   (dbus.rdata),
        .data_err_o     (dbus.err),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .viol_cnt_o     (viol_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, byte-enabled writes, read returns old data.
    always @(posedge clk) begin
        mem_rvalid <= mem_req;
        if (mem_req) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Monitor: pop the expected response when it falls due, else demand an idle port.
    always @(negedge clk) begin
        if (iq.size() != 0 && iq[0].due == cyc) begin
            ie = iq.pop_front();
            check("instr_rvalid", 32'(ibus.rvalid), 32'd1);
            check("instr_rdata", ibus.rdata, ie.rdata);
            check("instr_err", 32'(ibus.err), 32'(ie.err));
        end else begin
            check("instr_idle_rvalid", 32'(ibus.rvalid), 32'd0);
            check("instr_idle_err", 32'(ibus.err), 32'd0);
            check("instr_idle_rdata", ibus.rdata, 32'd0);
        end
        if (dq.size() != 0 && dq[0].due == cyc) begin
            de = dq.pop_front();
            check("data_rvalid", 32'(dbus.rvalid), 32'd1);
            check("data_rdata", dbus.rdata, de.rdata);
            check("data_err", 32'(dbus.err), 32'(de.err));
        end else begin
            check("data_idle_rvalid", 32'(dbus.rvalid), 32'd0);
            check("data_idle_err", 32'(dbus.err), 32'd0);
            check("data_idle_rdata", dbus.rdata, 32'd0);
        end
    end

    // One cycle of stimulus: check grant and RAM request, queue the expected response.
    task automatic drive(input logic        ireq,
                         input logic [31:0] iaddr,
                         input logic        dreq,
                         input logic        dwe,
                         input logic [3:0]  dbe,
                         input logic [31:0] daddr,
                         input logic [31:0] dwdata,
                         input logic        exp_ig,
                         input logic        exp_dg,
                         input logic        exp_mreq,
                         input logic [31:0] exp_rdata,
                         input logic        exp_err,
                         input logic        exp_resp);
        resp_t r;
        ibus.req   = ireq;
        ibus.addr  = iaddr;
        dbus.req   = dreq;
        dbus.we    = dwe;
        dbus.be    = dbe;
        dbus.addr  = daddr;
        dbus.wdata = dwdata;
        @(negedge clk);
        check("instr_gnt", 32'(ibus.gnt), 32'(exp_ig));
        check("data_gnt", 32'(dbus.gnt), 32'(exp_dg));
        check("mem_req", 32'(mem_req), 32'(exp_mreq));
        if (exp_mreq) begin
            check("mem_addr", 32'(mem_addr), (exp_ig ? iaddr : daddr) >> 2);
            check("mem_we", 32'(mem_we), exp_ig ? 32'd0 : 32'(dwe));
            check("mem_be", 32'(mem_be), exp_ig ? 32'hF : 32'(dbe));
            if (!exp_ig && dwe) check("mem_wdata", mem_wdata, dwdata);
        end else begin
            check("mem_idle", 32'(mem_addr) | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
        end
        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.due   = cyc + 1;
        if (exp_resp && exp_ig) iq.push_back(r);
        if (exp_resp && exp_dg) dq.push_back(r);
        @(posedge clk);
        #1;
        ibus.req = 1'b0;
        dbus.req = 1'b0;
        dbus.we  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'hA500_0000 | i;
        ram[32]    = 32'h0000_0013;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        ibus.req   = 1'b0;
        ibus.we    = 1'b0;
        ibus.be    = 4'hF;
        ibus.addr  = 32'd0;
        ibus.wdata = 32'd0;
        dbus.req   = 1'b0;
        dbus.we    = 1'b0;
        dbus.be    = 4'hF;
        dbus.addr  = 32'd0;
        dbus.wdata = 32'd0;

        // Reset held with both ports requesting: nothing may be granted.
        @(posedge clk);
        #1;
        repeat (2) drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        check("viol_cnt_reset", 32'(viol_cnt), 32'd0);
        rst = 1'b0;

        // Both ports request: D, I, D, I with matching responses one cycle later.
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 0, 1, 1, 32'hA500_0040, 0, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 0, 1, 1, 32'hA500_0040, 0, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);

        // Fetch at 0x80, and again with low address bits set.
        drive(1, 32'h80, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);
        drive(1, 32'h83, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);

        // Protected store is refused and counted; a load from the same place works.
        drive(0, 32'd0, 1, 1, 4'hF, 32'h2004, 32'hDEAD_BEEF, 0, 1, 0, 32'd0, 1, 1);
        check("viol_cnt_one", 32'(viol_cnt), 32'd1);
        drive(0, 32'd0, 1, 0, 4'hF, 32'h2004, 32'd0, 0, 1, 1, 32'hA500_0801, 0, 1);

        // Partial-byte store outside the window, then read it back.
        drive(0, 32'd0, 1, 1, 4'b0011, 32'h1000, 32'h1234_5678, 0, 1, 1, 32'hA500_0400, 0, 1);
        drive(0, 32'd0, 1, 0, 4'hF, 32'h1000, 32'd0, 0, 1, 1, 32'hA500_5678, 0, 1);

        // Window edges: just below base, last word inside, the limit itself.
        drive(0, 32'd0, 1, 1, 4'hF, 32'h1FFC, 32'h1111_1111, 0, 1, 1, 32'hA500_07FF, 0, 1);
        drive(0, 32'd0, 1, 1, 4'hF, 32'h2FFC, 32'h3333_3333, 0, 1, 0, 32'd0, 1, 1);
        drive(0, 32'd0, 1, 1, 4'hF, 32'h3000, 32'h2222_2222, 0, 1, 1, 32'hA500_0C00, 0, 1);
        drive(0, 32'd0, 1, 0, 4'hF, 32'h2FFC, 32'd0, 0, 1, 1, 32'hA500_0BFF, 0, 1);
        drive(0, 32'd0, 1, 0, 4'hF, 32'h1FFC, 32'd0, 0, 1, 1, 32'h1111_1111, 0, 1);
        drive(1, 32'h2004, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 1, 32'hA500_0801, 0, 1);
        check("viol_cnt_two", 32'(viol_cnt), 32'd2);

        // Out-of-range accesses answer with an error and never reach the RAM.
        drive(0, 32'd0, 1, 0, 4'hF, 32'h1_0000, 32'd0, 0, 1, 0, 32'd0, 1, 1);
        drive(0, 32'd0, 1, 0, 4'hF, 32'h0000_FFFC, 32'd0, 0, 1, 1, 32'hA500_3FFF, 0, 1);
        drive(1, 32'h1_0000, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 1);
        drive(1, 32'hFFFF_FFFC, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 0, 32'd0, 1, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h1_0000, 32'd0, 0, 1, 0, 32'd0, 1, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h1_0000, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);
        check("viol_cnt_still_two", 32'(viol_cnt), 32'd2);

        // Reset in the cycle after a legal fetch grant: no response may follow.
        drive(1, 32'h80, 0, 0, 4'hF, 32'd0, 32'd0, 1, 0, 1, 32'd0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_instr_rvalid", 32'(ibus.rvalid), 32'd0);
        check("rst_data_rvalid", 32'(dbus.rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the cycle after a protected store grant: counter ends at zero.
        drive(0, 32'd0, 1, 1, 4'hF, 32'h2008, 32'd0, 0, 1, 0, 32'd0, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_data_rvalid", 32'(dbus.rvalid), 32'd0);
        check("rst2_data_gnt", 32'(dbus.gnt), 32'd0);
        @(posedge clk);
        #1;
        check("viol_cnt_after_rst", 32'(viol_cnt), 32'd0);
        rst = 1'b0;
        drive(0, 32'd0, 0, 0, 4'hF, 32'd0, 32'd0, 0, 0, 0, 32'd0, 0, 0);

        // After reset the first tie goes to data again.
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 0, 1, 1, 32'hA500_0040, 0, 1);
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'd0, 1, 0, 1, 32'h0000_0013, 0, 1);

        // Violation counter saturation.
        for (int n = 0; n < 65534; n++) begin
            drive(0, 32'd0, 1, 1, 4'hF, 32'h2000, 32'd0, 0, 1, 0, 32'd0, 1, 1);
        end
        check("viol_cnt_fffe", 32'(viol_cnt), 32'h0000_FFFE);
        repeat (6) drive(0, 32'd0, 1, 1, 4'hF, 32'h2000, 32'd0, 0, 1, 0, 32'd0, 1, 1);
        check("viol_cnt_sat", 32'(viol_cnt), 32'h0000_FFFF);

        repeat (3) drive(0, 32'd0, 0, 0, 4'hF, 32'd0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        check("instr_queue_drained", 32'(iq.size()), 32'd0);
        check("data_queue_drained", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arb.md
IBEX_MEM_ARB -- requirements
Module: ibex_mem_arb

Interface
REQ-001 SHALL have parameter Depth, default 16384, RAM depth in 32-bit words.
REQ-002 SHALL have parameter ProtBase, default 32'h0000_2000, first byte address of the write-protected region.
REQ-003 SHALL have parameter ProtLimit, default 32'h0000_3000, the exclusive upper byte address of the write-protected region.
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous, active-high reset
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch error, valid with instr_rvalid_o
- data_req_i  in  1  load/store request
- data_we_i  in  1  store when 1
- data_be_i  in  4  byte enables
- data_addr_i  in  32  load/store byte address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store grant
- data_rvalid_o  out  1  load/store response valid
- data_rdata_o  out  32  load data
- data_err_o  out  1  load/store error, valid with data_rvalid_o
- mem_req_o  out  1  RAM request
- mem_we_o  out  1  RAM write
- mem_be_o  out  4  RAM byte enables
- mem_addr_o  out  $clog2(Depth)  RAM word address
- mem_wdata_o  out  32  RAM write data
- mem_rvalid_i  in  1  RAM response, one cycle after mem_req_o
- mem_rdata_i  in  32  RAM read data
- viol_cnt_o  out  16  protection-violation count

Function
REQ-005 SHALL grant at most one port per cycle; the grant is combinational, in the same cycle as the request.
REQ-006 SHALL arbitrate when both ports request: round-robin, with the last-granted port losing; data port wins the first tie after reset.
REQ-007 SHALL keep an owner register with states NONE, INSTR, DATA, ERR_I, ERR_D, loaded on grant and set to NONE when no grant occurs.
REQ-008 SHALL drive a granted, legal access to mem_* in the grant cycle: mem_addr_o = addr[$clog2(Depth)+1:2]; instr accesses use mem_we_o=0 and mem_be_o=4'hF.
REQ-009 SHALL, in the cycle after a grant with owner INSTR or DATA, assert exactly that port's rvalid, pass mem_rdata_i to it, and hold err=0.
REQ-010 SHALL treat addr >= Depth*4 on either port as illegal: the access is granted, no mem_req_o is issued, owner becomes ERR_I or ERR_D, and the next cycle gives rvalid=1, err=1, rdata=0.
REQ-011 SHALL treat a data store with ProtBase <= addr < ProtLimit as a violation: handled as in REQ-010, and viol_cnt_o increments by 1, saturating at 16'hFFFF.
REQ-012 SHALL allow data loads from the protected region and all instr fetches from it.
REQ-013 SHALL allow a new grant in the same cycle as a response, giving back-to-back throughput of 1 access/cycle.
REQ-014 SHALL drive rvalid, err and rdata low on any port not responding; mem_* outputs SHALL be 0 when mem_req_o=0.
REQ-015 SHALL not check alignment; the low address bits are ignored.

Reset
REQ-016 SHALL, while rst_i=1, set owner=NONE, round-robin pointer to favour data, viol_cnt_o=0, and hold all gnt, rvalid and mem_req_o outputs at 0.
REQ-017 SHALL drop any access granted in the cycle before reset: no rvalid follows it and a late mem_rvalid_i is ignored.

Structure
REQ-018 SHALL place the owner enum and the ProtBase/ProtLimit defaults in shared package ibex_mem_pkg.
REQ-019 SHALL be flat, with one optional sub-module ibex_mem_prot_chk (combinational range/legal decode).

Verification
REQ-020 Both ports request repeatedly from reset -> grants alternate D,I,D,I; each rvalid goes to the matching port one cycle later.
REQ-021 Instr fetch at 0x80 with RAM word 32 = 0x00000013 -> instr_rvalid_o=1 with rdata 0x00000013 and err=0, next cycle.
REQ-022 Data store to 0x2004 -> no mem_req_o; data_rvalid_o=1 with err=1 next cycle; viol_cnt_o 0->1; a load from 0x2004 succeeds.
REQ-023 Data load from 0x10000 with Depth=16384 -> data_err_o=1, rdata=0, mem untouched.
REQ-024 rst_i asserted the cycle after a grant -> no rvalid on either port, viol_cnt_o=0.
REQ-025 65540 protected stores -> viol_cnt_o holds at 16'hFFFF.
